// File: rtl/calculus_pkg.sv
// rtl/calculus_pkg.sv - opcodes, shift width and overflow narrowing shared by calculus_unit_pipe (CALC_SATURATE_EN selects clamping)
package calculus_pkg;

  localparam logic [3:0] FN_RELU  = 4'b0000;
  localparam logic [3:0] FN_ABS   = 4'b0010;
  localparam logic [3:0] FN_SIGN  = 4'b0011;
  localparam logic [3:0] FN_MIN   = 4'b0100;
  localparam logic [3:0] FN_MAX   = 4'b0101;
  localparam logic [3:0] FN_LRELU = 4'b0110;

  localparam int CALC_BIT_WIDTH = 32;
  localparam int SHIFT_W        = $clog2(CALC_BIT_WIDTH) + 1;

  // Brings an exact wide value into the signed w-bit range; callers keep the low w bits.
  function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] v, input int w);
`ifdef CALC_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/calculus_unit_pipe_lane.sv
// rtl/calculus_unit_pipe_lane.sv - calc_lane: one lane's stage-1 function and stage-2 requalify registers
module calc_lane
  import calculus_pkg::*;
#(
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld1_i,
  input  logic                        ld2_i,
  input  logic [FUNCTION_BITS-1:0]    fn_i,
  input  logic signed [BIT_WIDTH-1:0] a_i,
  input  logic signed [BIT_WIDTH-1:0] b_i,
  input  logic [7:0]                  dest_int_i,
  input  logic [7:0]                  src1_int_i,
  input  logic [7:0]                  src2_int_i,
  output logic [BIT_WIDTH-1:0]        data_o
);

  // Exact shift into 64 bits (valid for BIT_WIDTH <= 32); s > 0 shifts left.
  // Out-of-range left shifts return a value whose low bits are 0 but which still clamps by sign.
  function automatic logic signed [63:0] shift_wide(input logic signed [BIT_WIDTH-1:0] v, input int s);
    logic signed [63:0] vw;
    vw = {{(64-BIT_WIDTH){v[BIT_WIDTH-1]}}, v};
    if (s >= BIT_WIDTH)
      return (v == '0) ? 64'sd0 : (v[BIT_WIDTH-1] ? 64'sh8000_0000_0000_0000 : 64'sh4000_0000_0000_0000);
    else if (s >= 0)
      return vw <<< s;
    else if (-s >= BIT_WIDTH)
      return v[BIT_WIDTH-1] ? -64'sd1 : 64'sd0;
    else
      return vw >>> (-s);
  endfunction

  logic signed [BIT_WIDTH-1:0] b_al;
  logic signed [BIT_WIDTH:0]   a_x, b_x, r_x;
  logic signed [BIT_WIDTH-1:0] r_d, r_q;
  logic signed [8:0]           d_d, d_q;
  logic                        sign_q;
  logic signed [BIT_WIDTH-1:0] out_d, out_q;

  always_comb begin
    b_al = BIT_WIDTH'(sat_or_wrap(shift_wide(b_i, int'(src2_int_i) - int'(src1_int_i)), BIT_WIDTH));
    a_x  = {a_i[BIT_WIDTH-1], a_i};
    b_x  = {b_al[BIT_WIDTH-1], b_al};
    r_x  = '0;
    case (fn_i)
      FN_RELU:  r_x = a_i[BIT_WIDTH-1] ? '0 : a_x;
      FN_ABS:   r_x = a_i[BIT_WIDTH-1] ? -a_x : a_x;
      FN_SIGN:  r_x = a_i[BIT_WIDTH-1] ? '1 : ((a_i == '0) ? '0 : (BIT_WIDTH+1)'(1));
      FN_MIN:   r_x = (a_x < b_x) ? a_x : b_x;
      FN_MAX:   r_x = (a_x > b_x) ? a_x : b_x;
      FN_LRELU: r_x = a_i[BIT_WIDTH-1] ? (a_x >>> b_i[SHIFT_W-2:0]) : a_x;
      default:  r_x = '0;
    endcase
    r_d   = BIT_WIDTH'(sat_or_wrap({{(63-BIT_WIDTH){r_x[BIT_WIDTH]}}, r_x}, BIT_WIDTH));
    d_d   = $signed({1'b0, dest_int_i}) - $signed({1'b0, src1_int_i});
    // sign results are raw integers, never requalified
    out_d = sign_q ? r_q : BIT_WIDTH'(sat_or_wrap(shift_wide(r_q, -int'(d_q)), BIT_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      d_q    <= '0;
      sign_q <= 1'b0;
      out_q  <= '0;
    end else begin
      if (ld1_i) begin
        r_q    <= r_d;
        d_q    <= d_d;
        sign_q <= (fn_i == FN_SIGN);
      end
      if (ld2_i) out_q <= out_d;
    end
  end

  assign data_o = out_q;

endmodule

// File: rtl/calculus_unit_pipe.sv
// rtl/calculus_unit_pipe.sv - 2-stage multi-lane activation unit: handshake, stage valids, lane array
module calculus_unit_pipe
  import calculus_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FUNCTION_BITS-1:0]   fn,
  input  logic [LANES*BIT_WIDTH-1:0] data_in0,
  input  logic [LANES*BIT_WIDTH-1:0] data_in1,
  input  logic [7:0]                 dest_integer_bits,
  input  logic [7:0]                 src1_integer_bits,
  input  logic [7:0]                 src2_integer_bits,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BIT_WIDTH-1:0] data_out
);

  logic v1_q, v2_q, adv, ld1, ld2;

  // any stall freezes both stages together
  assign adv       = ~v2_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v2_q;
  assign ld1       = adv & in_valid;
  assign ld2       = adv & v1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    calc_lane #(
      .BIT_WIDTH    (BIT_WIDTH),
      .FUNCTION_BITS(FUNCTION_BITS)
    ) u_lane (
      .clk       (clk),
      .rst       (reset),
      .ld1_i     (ld1),
      .ld2_i     (ld2),
      .fn_i      (fn),
      .a_i       (data_in0[i*BIT_WIDTH +: BIT_WIDTH]),
      .b_i       (data_in1[i*BIT_WIDTH +: BIT_WIDTH]),
      .dest_int_i(dest_integer_bits),
      .src1_int_i(src1_integer_bits),
      .src2_int_i(src2_integer_bits),
      .data_o    (data_out[i*BIT_WIDTH +: BIT_WIDTH])
    );
  end

endmodule
